// File: rtl/modexp_sequencer_if.sv
// Byte-source / modexp-core bus for modexp_sequencer.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface modexp_sequencer_if #(
  parameter int DEPTH = 8
);
  logic [7:0]              byte_in;
  logic                    byte_valid_in;
  logic                    key_load_in;
  logic [7:0]              exponent_in;
  logic [7:0]              modulus_in;
  logic                    core_ready_out;
  logic [7:0]              core_value_out;
  logic [7:0]              core_exponent_out;
  logic [7:0]              core_modulus_out;
  logic                    core_busy_in;
  logic                    core_valid_in;
  logic [15:0]             core_result_in;
  logic [7:0]              result_out;
  logic                    result_valid_out;
  logic                    fifo_full_out;
  logic [$clog2(DEPTH):0]  fifo_count_out;
  logic                    key_valid_out;
  logic                    busy_out;
  logic                    overflow_out;
  logic                    result_err_out;
  logic                    timeout_out;

  modport slave (
    input  byte_in, byte_valid_in, key_load_in, exponent_in, modulus_in,
           core_busy_in, core_valid_in, core_result_in,
    output core_ready_out, core_value_out, core_exponent_out, core_modulus_out,
           result_out, result_valid_out, fifo_full_out, fifo_count_out,
           key_valid_out, busy_out, overflow_out, result_err_out, timeout_out
  );

  modport master (
    output byte_in, byte_valid_in, key_load_in, exponent_in, modulus_in,
           core_busy_in, core_valid_in, core_result_in,
    input  core_ready_out, core_value_out, core_exponent_out, core_modulus_out,
           result_out, result_valid_out, fifo_full_out, fifo_count_out,
           key_valid_out, busy_out, overflow_out, result_err_out, timeout_out
  );
endinterface

// File: rtl/modexp_sequencer.sv
// Front-end for the modexp core: byte FIFO, key latch, and the
// issue/wait/emit sequencer that owns all handshaking with the core.
module modexp_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  modexp_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [TW-1:0]   tmo_cnt;

  logic            core_ready, result_valid, full, key_valid, busy;
  logic            overflow, result_err, timeout;
  logic [7:0]      core_value, exp_q, mod_q, result;

  logic            full_now, push, pop, tmo_hit, res_bad;

  // Full is judged on the pre-edge count so a push never rides on a same-cycle pop.
  assign full_now  = (count == CW'(DEPTH));
  assign push      = bus.byte_valid_in && !full_now;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign res_bad   = (bus.core_result_in[15:8] != 8'd0) || (bus.core_result_in[7:0] >= mod_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (count != '0 && key_valid && !bus.core_busy_in && !bus.key_load_in) begin
        state_nxt = ISSUE;
        pop       = 1'b1;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.core_valid_in) begin
          state_nxt = EMIT;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          tmo_hit   = 1'b1;
        end
      end
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= bus.byte_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      core_ready   <= 1'b0;
      core_value   <= 8'd0;
      exp_q        <= 8'd0;
      mod_q        <= 8'd0;
      result       <= 8'd0;
      result_valid <= 1'b0;
      full         <= 1'b0;
      key_valid    <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      result_err   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        core_value <= mem[rd_ptr];
      end
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      busy         <= (state_nxt != IDLE) || (count_nxt != '0);
      core_ready   <= pop;
      result_valid <= (state == EMIT);
      if (bus.byte_valid_in && full_now) overflow <= 1'b1;
      if (state == IDLE && bus.key_load_in) begin
        exp_q     <= bus.exponent_in;
        mod_q     <= bus.modulus_in;
        key_valid <= (bus.modulus_in >= 8'd2);
      end
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == WAIT && bus.core_valid_in) begin
        result <= res_bad ? 8'd0 : bus.core_result_in[7:0];
        if (res_bad) result_err <= 1'b1;
      end
      if (tmo_hit) timeout <= 1'b1;
    end
  end

  assign bus.core_ready_out    = core_ready;
  assign bus.core_value_out    = core_value;
  assign bus.core_exponent_out = exp_q;
  assign bus.core_modulus_out  = mod_q;
  assign bus.result_out        = result;
  assign bus.result_valid_out  = result_valid;
  assign bus.fifo_full_out     = full;
  assign bus.fifo_count_out    = count;
  assign bus.key_valid_out     = key_valid;
  assign bus.busy_out          = busy;
  assign bus.overflow_out      = overflow;
  assign bus.result_err_out    = result_err;
  assign bus.timeout_out       = timeout;
endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: directed vectors, a behavioural core and
// FIFO model, a result scoreboard, and randomized traffic.
module tb_modexp_sequencer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modexp_sequencer_if #(.DEPTH(DEPTH)) bus();
  modexp_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  int n_cmp = 0, n_bad = 0, n_res = 0;
  int mq[$];      // bytes accepted but not yet issued
  int exp_q[$];   // results the sequencer owes us, in order
  int key_e = 0, key_n = 0;
  int force_en = 0, force_val = 0, core_lat = 0, core_rand = 0, mute_cnt = 0;
  bit core_pend = 1'b0;

  typedef struct {int e; int n; int b; int res; int exp_r; int exp_err;} vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modpow(input int b, input int e, input int n);
    int r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int reduce(input int res, input int n);
    if ((res >> 8) != 0 || (res & 255) >= n) return 0;
    return res & 255;
  endfunction

  task automatic push(input int b);
    bus.byte_in = 8'(b);
    bus.byte_valid_in = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(b);
    @(negedge clk);
    bus.byte_valid_in = 1'b0;
  endtask

  task automatic load_key(input int e, input int n, input bit accept);
    bus.exponent_in = 8'(e);
    bus.modulus_in  = 8'(n);
    bus.key_load_in = 1'b1;
    if (accept) begin key_e = e; key_n = n; end
    @(negedge clk);
    bus.key_load_in = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!bus.core_ready_out && k < budget) begin @(negedge clk); k++; end
    if (!bus.core_ready_out) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy_out || core_pend) && k < budget) begin
      @(negedge clk); k++;
    end
    if (k >= budget) check("wait_idle_timeout", 0, 1);
  endtask

  // Behavioural core: answers each start pulse with value^e mod n (or a forced value).
  initial begin
    int v, res, lat;
    bus.core_valid_in  = 1'b0;
    bus.core_result_in = 16'd0;
    forever begin
      @(negedge clk);
      if (bus.core_ready_out && !rst) begin
        core_pend = 1'b1;
        if (mq.size() == 0) begin
          check("unexpected_issue", 1, 0);
          v = 0;
        end else v = mq.pop_front();
        check("core_value", bus.core_value_out, v);
        check("core_exponent", bus.core_exponent_out, key_e);
        check("core_modulus", bus.core_modulus_out, key_n);
        lat = core_rand ? int'($urandom_range(0, 4)) : core_lat;
        res = force_en ? force_val : modpow(v, key_e, key_n);
        @(negedge clk);
        check("ready_width", bus.core_ready_out, 0);
        if (mute_cnt > 0) mute_cnt--;
        else begin
          repeat (lat) @(negedge clk);
          exp_q.push_back(reduce(res, key_n));
          bus.core_result_in = 16'(res);
          bus.core_valid_in  = 1'b1;
          @(negedge clk);
          bus.core_valid_in  = 1'b0;
        end
        core_pend = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.result_valid_out) begin
        n_res++;
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else check("result_order", bus.result_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    tbl[0] = '{7, 33, 5, 14, 14, 0};
    tbl[1] = '{3, 200, 10, 100, 100, 0};
    tbl[2] = '{1, 2, 1, 1, 1, 0};
    tbl[3] = '{7, 33, 5, 16'h0105, 0, 1};
    tbl[4] = '{7, 33, 5, 40, 0, 1};
    tbl[5] = '{7, 33, 5, 33, 0, 1};

    // Reset with random inputs on the pins
    bus.core_busy_in = 1'b0;
    repeat (2) begin
      bus.byte_in = 8'($urandom); bus.byte_valid_in = 1'($urandom);
      bus.key_load_in = 1'($urandom); bus.exponent_in = 8'($urandom);
      bus.modulus_in = 8'($urandom); bus.core_busy_in = 1'($urandom);
      @(negedge clk);
    end
    check("reset_outputs",
          {bus.core_ready_out, bus.core_value_out, bus.core_exponent_out, bus.core_modulus_out,
           bus.result_out, bus.result_valid_out, bus.fifo_full_out, bus.fifo_count_out,
           bus.key_valid_out, bus.overflow_out, bus.result_err_out, bus.timeout_out}, 0);
    check("reset_busy", bus.busy_out, 0);
    bus.byte_valid_in = 1'b0; bus.key_load_in = 1'b0; bus.core_busy_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed single-byte vectors (error rows last: the flag is sticky)
    for (int i = 0; i < 6; i++) begin
      load_key(tbl[i].e, tbl[i].n, 1'b1);
      force_en = 1; force_val = tbl[i].res;
      push(tbl[i].b);
      wait_idle(500);
      check($sformatf("vec%0d_result", i), bus.result_out, tbl[i].exp_r);
      check($sformatf("vec%0d_err", i), bus.result_err_out, tbl[i].exp_err);
      force_en = 0;
    end
    check("vec_no_overflow", bus.overflow_out, 0);
    check("vec_no_timeout", bus.timeout_out, 0);

    // Randomized traffic against the model
    load_key(int'($urandom_range(1, 20)), int'($urandom_range(2, 255)), 1'b1);
    core_rand = 1;
    base = n_res;
    for (int i = 0; i < 60; i++) begin
      if (mq.size() < DEPTH - 2 && $urandom_range(0, 1) == 1) push(int'($urandom_range(0, 255)));
      else @(negedge clk);
    end
    wait_idle(2000);
    core_rand = 0;
    check("rand_drained_fifo", bus.fifo_count_out, 0);
    check("rand_no_overflow", bus.overflow_out, 0);

    // Key gating: modulus 1 blocks issue, a good key releases it
    load_key(5, 1, 1'b1);
    check("gate_key_invalid", bus.key_valid_out, 0);
    push(3);
    check("gate_count", bus.fifo_count_out, 1);
    base = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.core_ready_out) base++;
      @(negedge clk);
    end
    check("gate_no_issue", base, 0);
    load_key(7, 33, 1'b1);
    check("gate_key_valid", bus.key_valid_out, 1);
    wait_idle(500);
    check("gate_result", bus.result_out, 9);

    // Key load during WAIT is ignored
    core_lat = 20;
    push(5);
    wait_ready(100);
    repeat (2) @(negedge clk);
    load_key(1, 99, 1'b0);
    check("wait_key_modulus", bus.core_modulus_out, 33);
    check("wait_key_exponent", bus.core_exponent_out, 7);
    wait_idle(500);
    core_lat = 0;

    // Timeout on the first byte, next byte still served
    mute_cnt = 1;
    push(10);
    push(11);
    wait_ready(100);
    repeat (TIMEOUT) @(negedge clk);
    check("timeout_not_early", bus.timeout_out, 0);
    @(negedge clk);
    check("timeout_set", bus.timeout_out, 1);
    wait_idle(500);
    check("timeout_next_result", bus.result_out, modpow(11, 7, 33));

    // Overflow and ordering with the core stalled
    check("pre_overflow_clear", bus.overflow_out, 0);
    bus.core_busy_in = 1'b1;
    for (int b = 1; b <= 9; b++) push(b);
    check("ovf_count", bus.fifo_count_out, DEPTH);
    check("ovf_full", bus.fifo_full_out, 1);
    check("ovf_flag", bus.overflow_out, 1);
    check("ovf_busy", bus.busy_out, 1);
    base = n_res;
    bus.core_busy_in = 1'b0;
    wait_idle(2000);
    check("ovf_results", n_res - base, DEPTH);
    check("ovf_empty", bus.fifo_full_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/modexp_sequencer.md
# modexp_sequencer

Front-end stage for the modular-exponentiation core. It buffers an incoming message byte stream in a small FIFO, latches the active key (exponent, modulus), and feeds bytes one at a time into the core over its ready/busy/valid handshake. It then emits each reduced 8-bit ciphertext/plaintext byte in order. The block sits between the byte source (UART/keypad path) and the modexp core, and owns all flow control around it.

## Interface
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 1024, max cycles spent in WAIT before aborting an operation.

- clk_in  input  1  system clock
- rst_in  input  1  reset; one clock, reset is synchronous and active-high
- byte_in  input  8  message byte to enqueue
- byte_valid_in  input  1  push strobe for byte_in
- key_load_in  input  1  latch exponent_in/modulus_in
- exponent_in  input  8  exponent to latch
- modulus_in  input  8  modulus to latch
- core_ready_out  output  1  one-cycle start pulse to core
- core_value_out  output  8  operand to core; held stable from ISSUE through end of WAIT
- core_exponent_out  output  8  latched exponent
- core_modulus_out  output  8  latched modulus
- core_busy_in  input  1  core busy
- core_valid_in  input  1  core done pulse
- core_result_in  input  16  core result
- result_out  output  8  reduced result byte
- result_valid_out  output  1  one-cycle strobe qualifying result_out
- fifo_full_out  output  1  FIFO holds DEPTH entries
- fifo_count_out  output  $clog2(DEPTH)+1  current FIFO occupancy
- key_valid_out  output  1  latched modulus ≥ 2
- busy_out  output  1  state ≠ IDLE or FIFO non-empty
- overflow_out  output  1  sticky; a push was dropped
- result_err_out  output  1  sticky; a core result had upper bits set or was ≥ modulus
- timeout_out  output  1  sticky; a WAIT expired

## Operation
- **FIFO**
  - Push on byte_valid_in when not full.
  - A push while full is dropped and sets overflow_out. Full is evaluated before any same-cycle pop.
  - A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- **Key load**
  - key_load_in is accepted only in IDLE. It latches exponent/modulus and sets key_valid_out = (modulus_in ≥ 2).
  - In any other state, key_load_in is ignored.
- **FSM** (states IDLE, ISSUE, WAIT, EMIT)
  - IDLE → ISSUE when count > 0, key_valid_out = 1, core_busy_in = 0, and key_load_in = 0. Entering ISSUE pops the FIFO head into core_value_out.
  - ISSUE: core_ready_out = 1 for exactly this one cycle, then → WAIT and clear the timeout counter.
  - WAIT:
    - On core_valid_in → EMIT. Latch result_out = core_result_in[7:0].
    - If core_result_in[15:8] ≠ 0 or core_result_in[7:0] ≥ modulus: set result_err_out and force result_out = 0.
    - If the counter reaches TIMEOUT: set timeout_out, discard the byte, → IDLE, no result.
  - EMIT: result_valid_out = 1 for one cycle, then → IDLE.
- Results appear in FIFO order; exactly one result or one timeout per popped byte.
- Sticky flags clear only on reset.

## Timing
- **Reset:**
  - All outputs 0: core_*_out = 0, result_out = 0, fifo_count_out = 0, key_valid_out = 0, all sticky flags 0.
  - FIFO empty, state IDLE, key registers 0.
- All outputs are registered.
- byte_valid_in at edge t → fifo_count_out updated after t.
- If IDLE with the entry present, ISSUE begins after edge t+1, and core_ready_out is high for the cycle following edge t+1.
- core_valid_in sampled at edge v → result_valid_out high for the cycle following v+1.
- Minimum turnaround per byte, excluding core latency: 4 cycles (IDLE, ISSUE, WAIT ≥ 1, EMIT).
- core_valid_in outside WAIT is ignored.
- Reset mid-operation aborts any in-flight byte with no result emitted. The FIFO contents are lost.

## Test plan
- **Reset:** Assert rst_in 2 cycles with random inputs → every output 0, busy_out = 0.
- **Single byte:**
  - Stimulus: load e = 7, n = 33; push 5.
  - core_ready_out pulses exactly 1 cycle, with core_value_out = 5, core_exponent_out = 7, core_modulus_out = 33.
  - The bench core model returns 14 → result_out = 14 with one result_valid_out pulse; no flags set.
- **Overflow / ordering:** DEPTH = 8; push 1..9 on consecutive cycles with the core stalled → byte 9 dropped, overflow_out = 1, fifo_full_out = 1. Releasing the core yields results for 1..8 in order.
- **Bad result:**
  - Model returns 0x0105 → result_out = 0, result_err_out = 1.
  - Model returns 40 with n = 33 → result_err_out = 1.
- **Timeout:** TIMEOUT = 64; the core never asserts valid → timeout_out set 64 cycles into WAIT, state returns to IDLE, and the next queued byte is issued normally.
- **Key gating:**
  - Load n = 1 → key_valid_out = 0; push 3 → no core_ready_out for 50 cycles.
  - Load n = 33 → the byte issues.
  - key_load_in during WAIT is ignored: core_modulus_out is unchanged.
